// File: rtl/axi_xbar_aw_w_steer.sv
// AW->W steering stage for one slave port of the crossbar demux: forwards AW to the
// decoded master port, queues the select in order, and steers W bursts until WLAST.
module axi_xbar_aw_w_steer #(
    parameter int unsigned NoMstPorts  = 4,
    parameter int unsigned MaxMstTrans = 8,
    parameter bit          FallThrough = 1'b0,
    parameter int unsigned SelWidth    = ($clog2(NoMstPorts) > 0) ? $clog2(NoMstPorts) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  slv_aw_valid_i,
    output logic                  slv_aw_ready_o,
    input  logic [SelWidth-1:0]   slv_aw_sel_i,
    output logic [NoMstPorts-1:0] mst_aw_valid_o,
    input  logic [NoMstPorts-1:0] mst_aw_ready_i,
    input  logic                  slv_w_valid_i,
    input  logic                  slv_w_last_i,
    output logic                  slv_w_ready_o,
    output logic [NoMstPorts-1:0] mst_w_valid_o,
    input  logic [NoMstPorts-1:0] mst_w_ready_i,
    output logic                  busy_o,
    output logic                  sel_err_o
);

    localparam int unsigned PtrW = (MaxMstTrans > 1) ? $clog2(MaxMstTrans) : 1;
    localparam int unsigned CntW = $clog2(MaxMstTrans + 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(MaxMstTrans);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxMstTrans - 1);

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrLast) ? '0 : p + 1'b1;
    endfunction

    logic [SelWidth-1:0]   fifo_mem [MaxMstTrans];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]       count_q;
    logic                  sel_err_q;

    logic                  sel_in_range, not_full, aw_ok, aw_hs;
    logic                  head_vld, w_act, ft_route, w_done, push, pop;
    logic [SelWidth-1:0]   w_sel;
    logic [NoMstPorts-1:0] w_onehot;

    assign sel_in_range = (32'(slv_aw_sel_i) < NoMstPorts);
    assign not_full     = (count_q < CntMax);
    assign aw_ok        = slv_aw_valid_i & not_full & sel_in_range;
    assign head_vld     = (count_q != '0);

    // AW path: valid is a pure function of request and FIFO space, never of ready
    always_comb begin
        mst_aw_valid_o = '0;
        for (int i = 0; i < NoMstPorts; i++) begin
            mst_aw_valid_o[i] = aw_ok && (32'(slv_aw_sel_i) == 32'(i));
        end
    end

    assign slv_aw_ready_o = aw_ok & (|(mst_aw_valid_o & mst_aw_ready_i));
    assign aw_hs          = slv_aw_ready_o;

    // W select: queued head first; bypass only when the queue is empty
    always_comb begin
        w_act    = 1'b0;
        ft_route = 1'b0;
        w_sel    = '0;
        if (!rst_i) begin
            if (head_vld) begin
                w_act = 1'b1;
                w_sel = fifo_mem[rd_ptr_q];
            end else if (FallThrough && aw_hs) begin
                w_act    = 1'b1;
                ft_route = 1'b1;
                w_sel    = slv_aw_sel_i;
            end
        end
    end

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NoMstPorts; i++) begin
            w_onehot[i] = w_act && (32'(w_sel) == 32'(i));
        end
    end

    assign mst_w_valid_o = w_onehot & {NoMstPorts{slv_w_valid_i}};
    assign slv_w_ready_o = |(w_onehot & mst_w_ready_i);

    assign w_done = slv_w_valid_i & slv_w_ready_o & slv_w_last_i;
    // A bypassed burst that finishes in its own AW cycle never needs a FIFO slot
    assign push   = aw_hs & ~(ft_route & w_done);
    assign pop    = head_vld & w_done;

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= slv_aw_sel_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            sel_err_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (slv_aw_valid_i && !sel_in_range) begin
                sel_err_q <= 1'b1;
            end
        end
    end

    assign busy_o    = head_vld;
    assign sel_err_o = sel_err_q;

endmodule

// File: tb/tb_axi_xbar_aw_w_steer.sv
// Bench for axi_xbar_aw_w_steer: queue-based model checked every cycle on two
// configurations, plus directed scenarios with literal expectations.
module tb_axi_xbar_aw_w_steer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: 4 ports, depth 8, no fall-through
    logic       a_awv, a_awr, a_wv, a_wl, a_wr, a_busy, a_err;
    logic [1:0] a_awsel;
    logic [3:0] a_mawv, a_mawr, a_mwv, a_mwr;
    // Instance B: 3 ports, depth 3, fall-through
    logic       b_awv, b_awr, b_wv, b_wl, b_wr, b_busy, b_err;
    logic [1:0] b_awsel;
    logic [2:0] b_mawv, b_mawr, b_mwv, b_mwr;

    axi_xbar_aw_w_steer #(.NoMstPorts(4), .MaxMstTrans(8), .FallThrough(1'b0)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .slv_aw_valid_i(a_awv), .slv_aw_ready_o(a_awr), .slv_aw_sel_i(a_awsel),
        .mst_aw_valid_o(a_mawv), .mst_aw_ready_i(a_mawr),
        .slv_w_valid_i(a_wv), .slv_w_last_i(a_wl), .slv_w_ready_o(a_wr),
        .mst_w_valid_o(a_mwv), .mst_w_ready_i(a_mwr),
        .busy_o(a_busy), .sel_err_o(a_err)
    );

    axi_xbar_aw_w_steer #(.NoMstPorts(3), .MaxMstTrans(3), .FallThrough(1'b1)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .slv_aw_valid_i(b_awv), .slv_aw_ready_o(b_awr), .slv_aw_sel_i(b_awsel),
        .mst_aw_valid_o(b_mawv), .mst_aw_ready_i(b_mawr),
        .slv_w_valid_i(b_wv), .slv_w_last_i(b_wl), .slv_w_ready_o(b_wr),
        .mst_w_valid_o(b_mwv), .mst_w_ready_i(b_mwr),
        .busy_o(b_busy), .sel_err_o(b_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: list of outstanding selects in acceptance order plus a sticky error bit
    int qa[$];
    int qb[$];
    bit ea, eb;
    bit a_push_n, a_pop_n, a_eset_n, b_push_n, b_pop_n, b_eset_n;
    int a_sel_n, b_sel_n;

    task automatic model(input int nports, input int depth, input bit ft, input bit in_rst,
                         input int cnt, input int head, input bit awv, input int awsel,
                         input logic [3:0] mawr, input bit wv, input bit wl, input logic [3:0] mwr,
                         output logic [3:0] e_awv, output bit e_awr,
                         output logic [3:0] e_wv, output bit e_wr,
                         output bit push, output bit pop);
        bit ok, act, byp, done;
        int s;
        ok    = awv && (cnt < depth) && (awsel < nports);
        e_awv = ok ? 4'(1 << awsel) : 4'b0;
        e_awr = ok && mawr[awsel];
        act = 1'b0; byp = 1'b0; s = 0;
        if (!in_rst && cnt > 0) begin
            act = 1'b1; s = head;
        end else if (!in_rst && ft && e_awr) begin
            act = 1'b1; byp = 1'b1; s = awsel;
        end
        e_wv = (act && wv) ? 4'(1 << s) : 4'b0;
        e_wr = act && mwr[s];
        done = e_wr && wv && wl;
        push = e_awr && !(byp && done) && !in_rst;
        pop  = (cnt > 0) && done && !in_rst;
    endtask

    always @(negedge clk) begin
        logic [3:0] eawv, ewv;
        bit eawr, ewr, pu, po;
        model(4, 8, 1'b0, rst, qa.size(), (qa.size() > 0) ? qa[0] : 0, a_awv, int'(a_awsel),
              a_mawr, a_wv, a_wl, a_mwr, eawv, eawr, ewv, ewr, pu, po);
        chk("a_mst_aw_valid", 32'(a_mawv), 32'(eawv));
        chk("a_slv_aw_ready", 32'(a_awr), 32'(eawr));
        chk("a_mst_w_valid", 32'(a_mwv), 32'(ewv));
        chk("a_slv_w_ready", 32'(a_wr), 32'(ewr));
        chk("a_busy", 32'(a_busy), 32'(qa.size() != 0));
        chk("a_sel_err", 32'(a_err), 32'(ea));
        a_push_n = pu; a_pop_n = po; a_sel_n = int'(a_awsel);
        a_eset_n = !rst && a_awv && (a_awsel >= 4);
        model(3, 3, 1'b1, rst, qb.size(), (qb.size() > 0) ? qb[0] : 0, b_awv, int'(b_awsel),
              {1'b0, b_mawr}, b_wv, b_wl, {1'b0, b_mwr}, eawv, eawr, ewv, ewr, pu, po);
        chk("b_mst_aw_valid", 32'(b_mawv), 32'(eawv));
        chk("b_slv_aw_ready", 32'(b_awr), 32'(eawr));
        chk("b_mst_w_valid", 32'(b_mwv), 32'(ewv));
        chk("b_slv_w_ready", 32'(b_wr), 32'(ewr));
        chk("b_busy", 32'(b_busy), 32'(qb.size() != 0));
        chk("b_sel_err", 32'(b_err), 32'(eb));
        b_push_n = pu; b_pop_n = po; b_sel_n = int'(b_awsel);
        b_eset_n = !rst && b_awv && (b_awsel >= 3);
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            qa.delete(); qb.delete();
            ea = 1'b0; eb = 1'b0;
            a_push_n = 1'b0; a_pop_n = 1'b0; a_eset_n = 1'b0;
            b_push_n = 1'b0; b_pop_n = 1'b0; b_eset_n = 1'b0;
        end else begin
            if (a_pop_n) void'(qa.pop_front());
            if (a_push_n) qa.push_back(a_sel_n);
            if (a_eset_n) ea = 1'b1;
            if (b_pop_n) void'(qb.pop_front());
            if (b_push_n) qb.push_back(b_sel_n);
            if (b_eset_n) eb = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    int ord[8] = '{1, 2, 3, 0, 1, 2, 3, 1};

    initial begin
        a_awv = 0; a_awsel = 0; a_mawr = 4'hF; a_wv = 0; a_wl = 0; a_mwr = 4'hF;
        b_awv = 0; b_awsel = 0; b_mawr = 3'h7; b_wv = 0; b_wl = 0; b_mwr = 3'h7;
        step(); step();
        chk("reset_busy", 32'(a_busy), 0);
        chk("reset_w_ready", 32'(a_wr), 0);
        chk("reset_w_valid", 32'(a_mwv), 0);
        chk("reset_sel_err", 32'(a_err), 0);
        rst = 1'b0;

        // Single burst, no fall-through: W waits one cycle, then 4 beats to port 2
        step(); a_awv = 1; a_awsel = 2; a_wv = 1; a_wl = 0; #2;
        chk("t1_aw_valid", 32'(a_mawv), 32'h4);
        chk("t1_aw_ready", 32'(a_awr), 1);
        chk("t1_w_ready_c0", 32'(a_wr), 0);
        chk("t1_w_valid_c0", 32'(a_mwv), 0);
        for (int i = 0; i < 4; i++) begin
            step(); a_awv = 0; a_wl = (i == 3); #2;
            chk("t1_w_valid", 32'(a_mwv), 32'h4);
            chk("t1_busy", 32'(a_busy), 1);
        end
        step(); a_wv = 0; a_wl = 0; #2;
        chk("t1_busy_after", 32'(a_busy), 0);

        // Fill eight entries with W held off
        for (int i = 0; i < 8; i++) begin
            step(); a_awv = 1; a_awsel = 2'(i % 4); #2;
            chk("t3_fill_ready", 32'(a_awr), 1);
        end
        step(); a_awsel = 1; #2;
        chk("t3_full_ready", 32'(a_awr), 0);
        chk("t3_full_valid", 32'(a_mawv), 0);
        // Release W; full FIFO with a same-cycle pop still refuses the AW
        step(); a_wv = 1; a_wl = 0; #2;
        chk("t3_w0", 32'(a_mwv), 32'h1);
        step(); a_wl = 1; #2;
        chk("t4_w0_last", 32'(a_mwv), 32'h1);
        chk("t4_aw_blocked", 32'(a_awr), 0);
        step(); a_wl = 0; #2;
        chk("t4_aw_next", 32'(a_awr), 1);
        chk("t3_w1", 32'(a_mwv), 32'h2);
        step(); a_awv = 0; a_wl = 1; #2;
        chk("t4_count_full", 32'(a_busy), 1);
        chk("t3_w1_last", 32'(a_mwv), 32'h2);
        for (int k = 1; k < 8; k++) begin
            step(); a_wl = 0; #2;
            chk("t3_order", 32'(a_mwv), 32'(1 << ord[k]));
            step(); a_wl = 1; #2;
            chk("t3_order_last", 32'(a_mwv), 32'(1 << ord[k]));
        end
        step(); a_wv = 0; a_wl = 0; #2;
        chk("t3_drained", 32'(a_busy), 0);

        // Backpressure from port 3 mid-burst
        step(); a_awv = 1; a_awsel = 3; #2;
        step(); a_awv = 0; a_wv = 1; a_wl = 0; #2;
        chk("t5_beat0_ready", 32'(a_wr), 1);
        step(); a_mwr = 4'b0111;
        for (int j = 0; j < 5; j++) begin
            #2;
            chk("t5_stall_ready", 32'(a_wr), 0);
            chk("t5_stall_valid", 32'(a_mwv), 32'h8);
            chk("t5_stall_busy", 32'(a_busy), 1);
            step();
        end
        a_mwr = 4'hF; a_wl = 1; #2;
        chk("t5_last_ready", 32'(a_wr), 1);
        step(); a_wv = 0; a_wl = 0; #2;
        chk("t5_popped", 32'(a_busy), 0);

        // Fall-through: single-beat W in the AW cycle, nothing queued
        step(); b_awv = 1; b_awsel = 1; b_wv = 1; b_wl = 1; #2;
        chk("t2_aw_valid", 32'(b_mawv), 32'h2);
        chk("t2_w_valid", 32'(b_mwv), 32'h2);
        chk("t2_w_ready", 32'(b_wr), 1);
        step(); b_awv = 0; b_wv = 0; b_wl = 0; #2;
        chk("t2_count0", 32'(b_busy), 0);
        // Bypassed burst not finished in its AW cycle keeps its entry
        step(); b_awv = 1; b_awsel = 2; b_wv = 1; b_wl = 0; #2;
        chk("t2b_bypass", 32'(b_mwv), 32'h4);
        step(); b_awsel = 0; b_wl = 1; #2;
        chk("t2b_head", 32'(b_mwv), 32'h4);
        chk("t2b_aw_ready", 32'(b_awr), 1);
        step(); b_awv = 0; #2;
        chk("t2b_next", 32'(b_mwv), 32'h1);
        step(); b_wv = 0; b_wl = 0; #2;
        chk("t2b_empty", 32'(b_busy), 0);

        // Out-of-range select on the 3-port instance
        step(); b_awv = 1; b_awsel = 3; #2;
        chk("t6_no_valid", 32'(b_mawv), 0);
        chk("t6_no_ready", 32'(b_awr), 0);
        chk("t6_err_before", 32'(b_err), 0);
        step(); #2;
        chk("t6_err_set", 32'(b_err), 1);
        step(); b_awv = 0; #2;
        chk("t6_err_sticky", 32'(b_err), 1);

        // Asynchronous reset in the middle of a burst
        step(); a_awv = 1; a_awsel = 0; #2;
        step(); a_awv = 0; a_wv = 1; a_wl = 0; #2;
        chk("t6_mid_busy", 32'(a_busy), 1);
        rst = 1'b1; #1;
        chk("t6_rst_busy", 32'(a_busy), 0);
        chk("t6_rst_w_ready", 32'(a_wr), 0);
        chk("t6_rst_w_valid", 32'(a_mwv), 0);
        chk("t6_rst_err", 32'(b_err), 0);
        step(); a_wv = 0; rst = 1'b0;
        step(); step(); #2;
        chk("t6_post_busy", 32'(a_busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
